// File: rtl/operand_sel_ctrl_pkg.sv
// Purpose: shared opcodes, operand-select codes, FSM states and EX payload type
//          for the ID/EX operand-select control stage.
// Ports:   none (package).
package operand_sel_pkg;

  // RV32I major opcodes (instruction[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Second-operand mux select codes
  localparam logic [2:0] SEL_PB    = 3'd0;
  localparam logic [2:0] SEL_IMM_I = 3'd1;
  localparam logic [2:0] SEL_IMM_S = 3'd2;
  localparam logic [2:0] SEL_IMM_U = 3'd3;
  localparam logic [2:0] SEL_PC    = 3'd4;
  localparam logic [2:0] SEL_ZERO  = 3'd5;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  // Contents of the EX pipeline slot; all-zero is a bubble.
  typedef struct packed {
    logic       valid;
    logic [2:0] s_sel;
    logic [4:0] rd;
    logic       reg_write;
    logic       is_load;
    logic       illegal;
  } ex_t;

endpackage

// File: rtl/operand_sel_ctrl_if.sv
// Purpose: ID-side inputs and EX-side outputs of the operand-select control stage.
// Ports:   master = pipeline driving ID/ready/flush and observing EX/stall;
//          slave  = operand_sel_ctrl.
interface operand_sel_ctrl_if;
  logic       id_valid;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] id_rd;
  logic       ex_ready;
  logic       flush;
  logic       id_stall;
  logic       ex_valid;
  logic [2:0] ex_s_sel;
  logic [4:0] ex_rd;
  logic       ex_reg_write;
  logic       ex_is_load;
  logic       ex_illegal;

  modport master (
    output id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_ready, flush,
    input  id_stall, ex_valid, ex_s_sel, ex_rd, ex_reg_write, ex_is_load, ex_illegal
  );

  modport slave (
    input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_ready, flush,
    output id_stall, ex_valid, ex_s_sel, ex_rd, ex_reg_write, ex_is_load, ex_illegal
  );
endinterface

// File: rtl/operand_sel_ctrl_decode.sv
// Purpose: combinational ID decode of opcode into operand select and control flags.
// Ports:   opcode_i/rd_i in; sel_o, uses_rs1_o, uses_rs2_o, reg_write_o,
//          is_load_o, illegal_o out. Zero latency, no handshake.
module operand_sel_decode
  import operand_sel_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [4:0] rd_i,
  output logic [2:0] sel_o,
  output logic       uses_rs1_o,
  output logic       uses_rs2_o,
  output logic       reg_write_o,
  output logic       is_load_o,
  output logic       illegal_o
);

  logic no_write;

  always_comb begin
    sel_o      = SEL_ZERO;
    uses_rs1_o = 1'b0;
    uses_rs2_o = 1'b0;
    is_load_o  = 1'b0;
    illegal_o  = 1'b0;
    no_write   = 1'b0;
    case (opcode_i)
      OP_R: begin
        sel_o      = SEL_PB;
        uses_rs1_o = 1'b1;
        uses_rs2_o = 1'b1;
      end
      OP_IMM, OP_JALR: begin
        sel_o      = SEL_IMM_I;
        uses_rs1_o = 1'b1;
      end
      OP_LOAD: begin
        sel_o      = SEL_IMM_I;
        uses_rs1_o = 1'b1;
        is_load_o  = 1'b1;
      end
      OP_STORE: begin
        sel_o      = SEL_IMM_S;
        uses_rs1_o = 1'b1;
        uses_rs2_o = 1'b1;
        no_write   = 1'b1;
      end
      OP_LUI, OP_AUIPC: sel_o = SEL_IMM_U;
      OP_JAL:           sel_o = SEL_PC;
      OP_BRANCH: begin
        sel_o      = SEL_PB;
        uses_rs1_o = 1'b1;
        uses_rs2_o = 1'b1;
        no_write   = 1'b1;
      end
      default: begin
        illegal_o = 1'b1;
        no_write  = 1'b1;
      end
    endcase
  end

  // Writes to x0 are architecturally discarded, so never flag them.
  assign reg_write_o = !no_write && (rd_i != 5'd0);

endmodule

// File: rtl/operand_sel_ctrl.sv
// Purpose: ID/EX operand-select control: decode, load-use hazard bubbles, EX register.
// Ports:   clk, rst_n (async active-low); bus (slave) carries ID inputs, ex_ready,
//          flush, combinational id_stall and registered ex_* outputs (1-cycle ID->EX).
module operand_sel_ctrl
  import operand_sel_pkg::*;
#(
  parameter int unsigned LOAD_USE_STALLS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  operand_sel_ctrl_if.slave bus
);

  // First hazard cycle already emits one bubble, so the counter covers the rest.
  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_USE_STALLS - 1);
  localparam logic       MULTI_STALL  = (LOAD_USE_STALLS > 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  ex_t        ex_q, ex_d;
  logic       stall;
  logic       hazard;

  logic [2:0] dec_sel;
  logic       dec_rs1, dec_rs2, dec_rw, dec_ld, dec_ill;

  operand_sel_decode u_decode (
    .opcode_i    (bus.id_opcode),
    .rd_i        (bus.id_rd),
    .sel_o       (dec_sel),
    .uses_rs1_o  (dec_rs1),
    .uses_rs2_o  (dec_rs2),
    .reg_write_o (dec_rw),
    .is_load_o   (dec_ld),
    .illegal_o   (dec_ill)
  );

  // Bubbles have ex_valid=0 and is_load=0, so they can never retrigger a stall.
  assign hazard = bus.id_valid && ex_q.valid && ex_q.is_load && (ex_q.rd != 5'd0) &&
                  ((dec_rs1 && (bus.id_rs1 == ex_q.rd)) ||
                   (dec_rs2 && (bus.id_rs2 == ex_q.rd)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ex_d    = ex_q;
    stall   = 1'b0;
    if (bus.flush) begin
      ex_d    = '0;
      state_d = ST_RUN;
      cnt_d   = 3'd0;
    end else if (!bus.ex_ready) begin
      stall = 1'b1;
    end else if (state_q == ST_STALL) begin
      stall = 1'b1;
      ex_d  = '0;
      cnt_d = cnt_q - 3'd1;
      if (cnt_q == 3'd1) state_d = ST_RUN;
    end else if (hazard) begin
      stall = 1'b1;
      ex_d  = '0;
      if (MULTI_STALL) begin
        state_d = ST_STALL;
        cnt_d   = STALL_RELOAD;
      end
    end else if (bus.id_valid) begin
      ex_d = '{valid: 1'b1, s_sel: dec_sel, rd: bus.id_rd,
               reg_write: dec_rw, is_load: dec_ld, illegal: dec_ill};
    end else begin
      ex_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= 3'd0;
      ex_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ex_q    <= ex_d;
    end
  end

  // Held low during reset even if EX reports not-ready.
  assign bus.id_stall     = stall && rst_n;
  assign bus.ex_valid     = ex_q.valid;
  assign bus.ex_s_sel     = ex_q.s_sel;
  assign bus.ex_rd        = ex_q.rd;
  assign bus.ex_reg_write = ex_q.reg_write;
  assign bus.ex_is_load   = ex_q.is_load;
  assign bus.ex_illegal   = ex_q.illegal;

endmodule

// File: tb/tb_operand_sel_ctrl.sv
// Purpose: self-checking bench for operand_sel_ctrl with LOAD_USE_STALLS=1 and =3
//          side by side on shared stimulus, each against a bubble-count reference model.
// Ports:   none (top-level bench).
module tb_operand_sel_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  operand_sel_ctrl_if if0 ();
  operand_sel_ctrl_if if1 ();

  operand_sel_ctrl #(.LOAD_USE_STALLS(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  operand_sel_ctrl #(.LOAD_USE_STALLS(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  // EX slot packed as {valid, sel[2:0], rd[4:0], reg_write, is_load, illegal}
  logic [11:0] obs_ex [2];
  logic        obs_stall [2];
  assign obs_ex[0] = {if0.ex_valid, if0.ex_s_sel, if0.ex_rd, if0.ex_reg_write, if0.ex_is_load, if0.ex_illegal};
  assign obs_ex[1] = {if1.ex_valid, if1.ex_s_sel, if1.ex_rd, if1.ex_reg_write, if1.ex_is_load, if1.ex_illegal};
  assign obs_stall[0] = if0.id_stall;
  assign obs_stall[1] = if1.id_stall;

  int lus [2] = '{1, 3};
  logic [11:0] m_ex [2];
  int m_bub [2];
  int stall_cnt [2];
  int errors = 0;
  int checks = 0;

  localparam logic [6:0] R_ = 7'b0110011, IMM = 7'b0010011, LD = 7'b0000011,
                         ST = 7'b0100011, LUI = 7'b0110111, AUI = 7'b0010111,
                         JAL = 7'b1101111, JALR = 7'b1100111, BR = 7'b1100011;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference decode straight from the opcode table.
  function automatic logic [11:0] ref_dec(input logic [6:0] op, input logic [4:0] rd,
                                          output logic u1, output logic u2);
    int sel;
    bit ld, ill, nowr;
    sel = 5; u1 = 0; u2 = 0; ld = 0; ill = 0; nowr = 0;
    case (op)
      7'b0110011: begin sel = 0; u1 = 1; u2 = 1; end
      7'b0010011, 7'b1100111: begin sel = 1; u1 = 1; end
      7'b0000011: begin sel = 1; u1 = 1; ld = 1; end
      7'b0100011: begin sel = 2; u1 = 1; u2 = 1; nowr = 1; end
      7'b0110111, 7'b0010111: sel = 3;
      7'b1101111: sel = 4;
      7'b1100011: begin sel = 0; u1 = 1; u2 = 1; nowr = 1; end
      default: begin ill = 1; nowr = 1; end
    endcase
    return {1'b1, 3'(sel), rd, (!nowr && rd != 0), ld, ill};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ex[k] = '0;
      m_bub[k] = 0;
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] r1, r2, rd,
                       input logic rdy, input logic fl);
    if0.id_valid = v;  if0.id_opcode = op; if0.id_rs1 = r1; if0.id_rs2 = r2;
    if0.id_rd = rd;    if0.ex_ready = rdy; if0.flush = fl;
    if1.id_valid = v;  if1.id_opcode = op; if1.id_rs1 = r1; if1.id_rs2 = r2;
    if1.id_rd = rd;    if1.ex_ready = rdy; if1.flush = fl;
  endtask

  // One pipeline cycle: check combinational stall mid-cycle, EX contents after the edge.
  task automatic step(input logic v, input logic [6:0] op, input logic [4:0] r1, r2, rd,
                      input logic rdy, input logic fl);
    logic [11:0] nx [2];
    logic [11:0] d;
    logic u1, u2, haz, st;
    @(negedge clk);
    drive(v, op, r1, r2, rd, rdy, fl);
    #1;
    for (int k = 0; k < 2; k++) begin
      d = ref_dec(op, rd, u1, u2);
      haz = v && m_ex[k][11] && m_ex[k][1] && (m_ex[k][7:3] != 0) &&
            ((u1 && r1 == m_ex[k][7:3]) || (u2 && r2 == m_ex[k][7:3]));
      if (fl) begin
        nx[k] = '0; m_bub[k] = 0; st = 0;
      end else if (!rdy) begin
        nx[k] = m_ex[k]; st = 1;
      end else if (m_bub[k] > 0) begin
        nx[k] = '0; m_bub[k]--; st = 1;
      end else if (haz) begin
        nx[k] = '0; m_bub[k] = lus[k] - 1; st = 1;
      end else begin
        nx[k] = v ? d : 12'h0; st = 0;
      end
      chk($sformatf("id_stall%0d", k), 32'(obs_stall[k]), 32'(st));
      if (obs_stall[k]) stall_cnt[k]++;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_ex[k] = nx[k];
      chk($sformatf("ex%0d", k), 32'(obs_ex[k]), 32'(m_ex[k]));
    end
  endtask

  task automatic drain();
    repeat (4) step(0, IMM, 0, 0, 0, 1, 0);
    stall_cnt[0] = 0;
    stall_cnt[1] = 0;
  endtask

  logic [6:0] sweep_op [10] = '{R_, IMM, LD, ST, LUI, AUI, JAL, JALR, BR, 7'b0000000};
  int         sweep_sel [10] = '{0, 1, 1, 2, 3, 3, 4, 1, 0, 5};
  logic [6:0] rnd_op [10] = '{R_, IMM, LD, ST, LUI, AUI, JAL, JALR, BR, LD};

  initial begin
    model_reset();
    drive(1, R_, 0, 0, 1, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_ex0", 32'(obs_ex[0]), 0);
    chk("rst_ex1", 32'(obs_ex[1]), 0);
    chk("rst_stall0", 32'(obs_stall[0]), 0);
    chk("rst_stall1", 32'(obs_stall[1]), 0);
    rst_n = 1'b1;

    // Opcode sweep
    for (int i = 0; i < 10; i++) begin
      step(1, sweep_op[i], 0, 0, 1, 1, 0);
      chk("sweep_sel", 32'(obs_ex[0][10:8]), 32'(sweep_sel[i]));
      chk("sweep_ill", 32'(obs_ex[0][0]), (i == 9) ? 1 : 0);
    end

    // Load-use: LW x5 ; ADD x6,x5,x1
    drain();
    step(1, LD, 0, 0, 5, 1, 0);
    repeat (5) step(1, R_, 5, 1, 6, 1, 0);
    chk("lu_stalls_n1", 32'(stall_cnt[0]), 1);
    chk("lu_stalls_n3", 32'(stall_cnt[1]), 3);

    // Load into x0: no hazard
    drain();
    step(1, LD, 0, 0, 0, 1, 0);
    step(1, R_, 0, 0, 6, 1, 0);
    chk("x0_stalls", 32'(stall_cnt[0] + stall_cnt[1]), 0);

    // LUI consumer ignores its rs fields
    drain();
    step(1, LD, 0, 0, 5, 1, 0);
    step(1, LUI, 5, 5, 7, 1, 0);
    chk("lui_stalls", 32'(stall_cnt[0] + stall_cnt[1]), 0);

    // Not-ready during the second bubble extends the stall
    drain();
    step(1, LD, 0, 0, 5, 1, 0);
    step(1, R_, 5, 1, 6, 1, 0);
    step(1, R_, 5, 1, 6, 1, 0);
    step(1, R_, 5, 1, 6, 0, 0);
    step(1, R_, 5, 1, 6, 0, 0);
    repeat (3) step(1, R_, 5, 1, 6, 1, 0);
    chk("bp_stalls_n3", 32'(stall_cnt[1]), 5);

    // Flush on the second stall cycle
    drain();
    step(1, LD, 0, 0, 5, 1, 0);
    step(1, R_, 5, 1, 6, 1, 0);
    step(1, R_, 5, 1, 6, 1, 1);
    chk("flush_bubble", 32'(obs_ex[1][11]), 0);
    step(1, R_, 5, 1, 6, 1, 0);
    chk("flush_resume", 32'(obs_ex[1][11]), 1);
    chk("flush_stalls", 32'(stall_cnt[1]), 1);

    // Back-pressure holding a store
    drain();
    step(1, ST, 0, 0, 3, 1, 0);
    repeat (4) begin
      step(1, IMM, 0, 0, 4, 0, 0);
      chk("bp_sel", 32'(obs_ex[0][10:8]), 2);
      chk("bp_vld", 32'(obs_ex[0][11]), 1);
    end
    chk("bp_stall_cnt", 32'(stall_cnt[0]), 4);
    step(1, IMM, 0, 0, 4, 1, 0);
    chk("bp_release", 32'(obs_ex[0][10:8]), 1);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) != 0),
           ($urandom_range(0, 10) == 10) ? 7'($urandom) : rnd_op[$urandom_range(0, 9)],
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 4) != 0), ($urandom_range(0, 19) == 0));
    end

    // Asynchronous reset while EX is occupied
    drain();
    step(1, IMM, 0, 0, 2, 1, 0);
    chk("pre_rst_vld", 32'(obs_ex[0][11]), 1);
    #2;
    drive(1, IMM, 0, 0, 2, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_ex0", 32'(obs_ex[0]), 0);
    chk("arst_ex1", 32'(obs_ex[1]), 0);
    chk("arst_stall", 32'(obs_stall[0] | obs_stall[1]), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, IMM, 0, 0, 2, 1, 0);
    chk("post_rst_sel", 32'(obs_ex[0][10:8]), 1);
    chk("post_rst_vld", 32'(obs_ex[1][11]), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_sel_ctrl.md
Name: operand_sel_ctrl

Overview:
ID/EX control stage for the RV32I PPU. Decodes the ID-stage opcode into the 3-bit second-operand select that drives the second-operand mux in EX, and registers that select with rd and control flags into the EX stage. Detects load-use hazards, inserts parameterised bubbles, honours EX back-pressure and pipeline flush. Emits the freeze signal for IF/ID.

Parameters:
LOAD_USE_STALLS, 1, bubbles inserted per load-use hazard (legal range 1..7)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID stage holds a valid instruction
id_opcode  in  7  instruction[6:0]
id_rs1  in  5  instruction[19:15]
id_rs2  in  5  instruction[24:20]
id_rd  in  5  instruction[11:7]
ex_ready  in  1  EX can accept a new instruction this cycle
flush  in  1  branch/jump redirect; kill ID and EX contents
id_stall  out  1  freeze PC and IF/ID (combinational)
ex_valid  out  1  EX slot holds a real instruction
ex_s_sel  out  3  second-operand select for EX mux
ex_rd  out  5  destination register
ex_reg_write  out  1  EX instruction writes rd
ex_is_load  out  1  EX instruction is a load
ex_illegal  out  1  EX instruction had an unrecognised opcode

Behaviour:
- Reset (rst_n=0, async): all ex_* outputs 0, state RUN, counter 0. id_stall is 0 while in reset.
- Decode (combinational, ID):
  - 0110011 R: sel 0 (PB), rs1 and rs2 used.
  - 0010011 I-ALU, 0000011 load, 1100111 JALR: sel 1 (sign-extended imm12_I), rs1 used.
  - 0100011 store: sel 2 (sign-extended imm12_S), rs1 and rs2 used.
  - 0110111 LUI, 0010111 AUIPC: sel 3 (imm20<<12), no rs used.
  - 1101111 JAL: sel 4 (PC), no rs used.
  - 1100011 branch: sel 0, rs1 and rs2 used.
  - Any other opcode: sel 5 (zero) and illegal=1.
- reg_write is 1 except for store, branch, illegal opcodes, or rd==0.
- is_load is set only for opcode 0000011.
- Hazard: id_valid & ex_valid & ex_is_load & ex_rd!=0 & ((uses_rs1 & id_rs1==ex_rd) | (uses_rs2 & id_rs2==ex_rd)).
- Priority each cycle: flush > !ex_ready > STALL state > hazard > normal.
  - flush: next EX is a bubble (ex_valid=0, all ex_* flags 0); state becomes RUN; counter cleared; id_stall=0.
  - !ex_ready: EX register holds; state and counter hold; id_stall=1.
  - RUN with hazard: id_stall=1; next EX is a bubble. If LOAD_USE_STALLS>1, go to STALL with counter=LOAD_USE_STALLS-1; otherwise stay in RUN.
  - STALL: id_stall=1; next EX is a bubble; counter decrements. When counter==1, return to RUN.
  - Normal: EX loads the decode of ID with ex_valid=id_valid; id_stall=0.
- Total bubbles per hazard equals LOAD_USE_STALLS exactly.
- The ID to EX latency is 1 cycle.
- A bubble never triggers a hazard, so no double stall occurs.
- When id_valid=0 in a normal cycle, EX loads a bubble. ex_s_sel is then don't-care and is driven as 0.

Decomposition:
- Package operand_sel_pkg holds:
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - select codes SEL_PB=0, SEL_IMM_I=1, SEL_IMM_S=2, SEL_IMM_U=3, SEL_PC=4, SEL_ZERO=5;
  - state encoding ST_RUN, ST_STALL.
- One combinational sub-module, operand_sel_decode: opcode and rd in; sel, uses_rs1, uses_rs2, reg_write, is_load, illegal out.
- The hazard check, FSM and EX register stay in the top module.

Test Plan:
- Reset mid-stream: assert rst_n=0 while ex_valid=1 -> all ex_* are 0 immediately (asynchronously); after release, first ADDI (0010011) appears as ex_s_sel=1, ex_valid=1 one cycle later.
- Opcode sweep: feed R, I, load, store, LUI, AUIPC, JAL, JALR, branch, 0000000 back-to-back -> ex_s_sel sequence 0,1,1,2,3,3,4,1,0,5. ex_illegal=1 only on the last one; ex_reg_write=0 for store, branch and the illegal opcode.
- Load-use, LOAD_USE_STALLS=1: LW x5 followed by ADD x6,x5,x1 -> id_stall=1 for exactly 1 cycle; one bubble appears, then ADD enters EX. With x0 as the LW rd, or LUI x7 as the consumer: no stall.
- Load-use, LOAD_USE_STALLS=3: same sequence -> id_stall high for 3 cycles, 3 bubbles, then ADD. With ex_ready=0 during the second bubble: counter freezes and the stall extends by the number of not-ready cycles.
- Flush during STALL (LOAD_USE_STALLS=3, flush on the 2nd stall cycle): next cycle ex_valid=0, state RUN, id_stall=0. The following instruction enters EX normally.
- Back-pressure: ex_ready=0 for 4 cycles holding a SW in EX -> ex_s_sel stays 2 and ex_valid stays 1, id_stall=1 throughout. On release the next instruction advances in 1 cycle.
